// File: rtl/sub_divider_ctrl_pkg.sv
// Shared constants and state encoding for the subtractor-based divide sequencer.
package sub_divider_ctrl_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned CNT_W     = 6;

  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT_DEF = 32'hFFFF_FFFF;
  localparam logic [CNT_W-1:0]     LAST_ITER        = CNT_W'(31);
  localparam logic [CNT_W-1:0]     CNT_ONE          = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sub_divider_ctrl_if.sv
// Request/result bundle between the ALU op decoder (master) and the divide sequencer (slave).
interface sub_divider_ctrl_if;
  import sub_divider_ctrl_pkg::*;

  logic                 start;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic                 busy;
  logic                 done;
  logic [DIV_WIDTH-1:0] quotient;
  logic [DIV_WIDTH-1:0] remainder;
  logic                 div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/full_subtractor_32.sv
// 32-bit ripple-borrow subtractor: diff = x - y - bin, bout set when the result underflows.
module full_subtractor_32 (
  output logic        bout,
  output logic [31:0] diff,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        bin
);

  logic b;

  always_comb begin
    diff = '0;
    b    = bin;
    for (int i = 0; i < 32; i++) begin
      diff[i] = x[i] ^ y[i] ^ b;
      b       = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & b);
    end
    bout = b;
  end

endmodule

// File: rtl/sub_divider_ctrl.sv
// Unsigned 32/32 restoring divider: one quotient bit per clock through the shared ripple subtractor.
module sub_divider_ctrl
  import sub_divider_ctrl_pkg::*;
#(
  parameter logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = DBZ_QUOTIENT_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  sub_divider_ctrl_if.slave  div_if,
  output state_e             state_o
);

  // Handshake: start is sampled only while busy=0 (IDLE); busy stays high from the
  // accepting edge through the DONE state; done is a one-cycle pulse with results valid.
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] q_q, q_d, r_q, r_d, dvsr_q, dvsr_d;
  logic                 dbz_q, dbz_d;
  logic                 done_q, done_d;
  logic [DIV_WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic                 dbzo_q, dbzo_d;

  logic [DIV_WIDTH-1:0] shifted, diff;
  logic                 carry, bout;

  assign shifted = {r_q[DIV_WIDTH-2:0], q_q[DIV_WIDTH-1]};
  assign carry   = r_q[DIV_WIDTH-1];

  full_subtractor_32 u_sub (
    .bout (bout),
    .diff (diff),
    .x    (shifted),
    .y    (dvsr_q),
    .bin  (1'b0)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dvsr_d  = dvsr_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbzo_d  = dbzo_q;
    unique case (state_q)
      S_IDLE: begin
        if (div_if.start) begin
          if (div_if.divisor != '0) begin
            dvsr_d  = div_if.divisor;
            q_d     = div_if.dividend;
            r_d     = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = S_CALC;
          end else begin
            q_d     = DBZ_QUOTIENT;
            r_d     = div_if.dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_CALC: begin
        // A set carry means the true partial remainder is >= 2^32, so the wrapped diff is exact.
        if (carry || !bout) begin
          r_d = diff;
          q_d = {q_q[DIV_WIDTH-2:0], 1'b1};
        end else begin
          r_d = shifted;
          q_d = {q_q[DIV_WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == LAST_ITER) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        quot_d  = q_q;
        rem_d   = r_q;
        dbzo_d  = dbz_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dvsr_q  <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbzo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dvsr_q  <= dvsr_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbzo_q  <= dbzo_d;
    end
  end

  assign div_if.busy        = (state_q != S_IDLE);
  assign div_if.done        = done_q;
  assign div_if.quotient    = quot_q;
  assign div_if.remainder   = rem_q;
  assign div_if.div_by_zero = dbzo_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_sub_divider_ctrl.sv
// Directed bench for sub_divider_ctrl: reference results queued at start, checked at done.
module tb_sub_divider_ctrl;
  import sub_divider_ctrl_pkg::*;

  logic   clk;
  logic   reset_n;
  state_e dbg_state;
  int     n_checks = 0;
  int     n_err    = 0;
  logic [64:0] exp_q[$];

  sub_divider_ctrl_if dif ();

  sub_divider_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .div_if  (dif),
    .state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] model(input logic [31:0] dvd, input logic [31:0] dvs);
    if (dvs == 32'd0) return {1'b1, 32'hFFFF_FFFF, dvd};
    return {1'b0, dvd / dvs, dvd % dvs};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one accepted start (caller is just after an edge with busy=0) and queues its result.
  task automatic start_op(input logic [31:0] dvd, input logic [31:0] dvs);
    dif.start    = 1'b1;
    dif.dividend = dvd;
    dif.divisor  = dvs;
    exp_q.push_back(model(dvd, dvs));
    tick();
    dif.start    = 1'b0;
    dif.dividend = $urandom;
    dif.divisor  = $urandom;
    check("done_low_after_accept", 64'(dif.done), 64'd0);
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input int inject_at);
    int lat = 0;
    int busy_cnt = 0;
    bit seen = 1'b0;
    logic [64:0] e;
    if (dif.busy) busy_cnt++;
    while (!seen && lat < 40) begin
      if (inject_at != 0 && lat == inject_at) begin
        dif.start    = 1'b1;
        dif.dividend = 32'd1000;
        dif.divisor  = 32'd3;
      end else begin
        dif.start = 1'b0;
      end
      tick();
      lat++;
      if (dif.done) seen = 1'b1;
      else if (dif.busy) busy_cnt++;
    end
    dif.start = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_in_done_cycle"}, 64'(dif.busy), 64'd0);
    if (exp_lat == 33) check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_quotient"}, 64'(dif.quotient), 64'(e[63:32]));
      check({tag, "_remainder"}, 64'(dif.remainder), 64'(e[31:0]));
      check({tag, "_div_by_zero"}, 64'(dif.div_by_zero), 64'(e[64]));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(dif.busy), 64'd0);
    check({tag, "_done"}, 64'(dif.done), 64'd0);
    check({tag, "_quotient"}, 64'(dif.quotient), 64'd0);
    check({tag, "_remainder"}, 64'(dif.remainder), 64'd0);
    check({tag, "_div_by_zero"}, 64'(dif.div_by_zero), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    reset_n      = 1'b0;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (3) tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    start_op(32'd100, 32'd7);
    wait_done("d100_7", 33, 0);
    check("d100_7_q_const", 64'(dif.quotient), 64'd14);
    check("d100_7_r_const", 64'(dif.remainder), 64'd2);
    tick();
    check("done_single_pulse", 64'(dif.done), 64'd0);

    start_op(32'hE9EE_C208, 32'h583B_D1CC);
    wait_done("big_pair", 33, 0);
    check("big_pair_r_const", 64'(dif.remainder), 64'h39771E70);

    start_op(32'hFFFF_FFFF, 32'd1);
    wait_done("max_by_1", 33, 0);
    start_op(32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("msb_by_max", 33, 0);

    start_op(32'h1234_5678, 32'd0);
    wait_done("dbz", 1, 0);
    start_op(32'd9, 32'd3);
    wait_done("after_dbz", 33, 0);

    repeat (5) tick();
    check("hold_quotient", 64'(dif.quotient), 64'd3);
    check("hold_remainder", 64'(dif.remainder), 64'd0);
    check("hold_dbz", 64'(dif.div_by_zero), 64'd0);
    check("hold_done", 64'(dif.done), 64'd0);

    start_op(32'd100, 32'd7);
    wait_done("ignore_busy_start", 33, 10);
    start_op(32'd50, 32'd5);
    wait_done("back_to_back", 33, 0);

    start_op(32'd1000, 32'd3);
    repeat (14) tick();
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_op_reset");
    exp_q.delete();
    repeat (3) tick();
    check("reset_no_done", 64'(dif.done), 64'd0);
    reset_n = 1'b1;
    tick();
    start_op(32'd7, 32'd7);
    wait_done("after_reset", 33, 0);

    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      start_op(a, b);
      wait_done("random", 33, 0);
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
